// File: rtl/cla_pkg.sv
// Shared types and constants for the serial carry-lookahead adder.
// Holds the FSM state encoding, the digit width and the counter-width helper.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 2;

    // One extra bit so the counter can represent DIGITS itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width / DIGIT_W) + 1;
    endfunction

endpackage

// File: rtl/cla_slice2.sv
// Combinational 2-bit carry-lookahead slice.
// Exposes the internal carry c1 so the top can derive signed overflow.
module cla_slice2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       c1,
    output logic       cout
);

    logic [1:0] g;
    logic [1:0] p;

    assign g    = x & y;
    assign p    = x ^ y;
    assign c1   = g[0] | (p[0] & cin);
    assign cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign sum  = p ^ {c1, cin};

endmodule

// File: rtl/serial_cla_adder.sv
// WIDTH-bit adder that resolves two bits per cycle through one cla_slice2.
// Optional signed-overflow output ovf is enabled by defining SERIAL_CLA_OVF_EN.
module serial_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef SERIAL_CLA_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W  = cnt_width(WIDTH);

    generate
        if ((WIDTH < DIGIT_W) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_width
            $error("serial_cla_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   k;

    logic [DIGIT_W-1:0] sum_dig;
    logic               c1_dig;
    logic               co_dig;
    logic               last_dig;

    // Operands are shifted right each digit, so the slice always sees bits [1:0].
    cla_slice2 u_slice (
        .x    (a_reg[DIGIT_W-1:0]),
        .y    (b_reg[DIGIT_W-1:0]),
        .cin  (carry_reg),
        .sum  (sum_dig),
        .c1   (c1_dig),
        .cout (co_dig)
    );

    assign last_dig = (k == CNT_W'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            s         <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_CLA_OVF_EN
            ovf       <= 1'b0;
`endif
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= ci;
                        k         <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> DIGIT_W;
                    b_reg     <= b_reg >> DIGIT_W;
                    carry_reg <= co_dig;
                    k         <= k + 1'b1;
                    // New digit enters at the top; after DIGITS shifts digit 0 sits at bit 0.
                    s         <= (s >> DIGIT_W) | (WIDTH'(sum_dig) << (WIDTH - DIGIT_W));
                    if (last_dig) begin
                        cout      <= co_dig;
`ifdef SERIAL_CLA_OVF_EN
                        ovf       <= c1_dig ^ co_dig;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifndef SERIAL_CLA_OVF_EN
    logic unused_c1;
    assign unused_c1 = c1_dig;
`endif

endmodule
